// File: rtl/ohs_boost_interleaved_l2.sv
// Level-2 N-phase interleaved boost converter model; one multiplier shared across a multi-clock step.
// Define OHS_BOOST_DCM_EN to clamp open-switch phase currents at zero (ideal diode, DCM).
module ohs_boost_interleaved_l2 #(
    parameter int data_width   = 32,
    parameter int data_decimal = 22,
    parameter int n_phases     = 2
) (
    input  logic                             aclk,
    input  logic                             resetn,
    input  logic                             ce,
    input  logic [data_width-1:0]            kL,
    input  logic [data_width-1:0]            kC,
    input  logic [data_width-1:0]            kR,
    input  logic [data_width-1:0]            vdc,
    input  logic [n_phases-1:0]              S_pwm,
    output logic [n_phases*data_width-1:0]   iL,
    output logic [data_width-1:0]            iC,
    output logic [data_width-1:0]            vC,
    output logic [data_width-1:0]            iLoad,
    output logic                             busy,
    output logic                             valid,
    output logic                             overrun
);

    // Operands carry one guard bit so vdc - vC can never wrap.
    localparam int ow    = data_width + 1;
    localparam int pw    = 2 * ow;
    localparam int sw    = data_width + 3;
    localparam int cnt_w = (n_phases > 1) ? $clog2(n_phases) : 1;

    localparam logic [cnt_w-1:0]     last_phase = cnt_w'(n_phases - 1);
    localparam logic signed [pw-1:0] sat_hi     = pw'({1'b0, {(data_width-1){1'b1}}});
    localparam logic signed [pw-1:0] sat_lo     = ~sat_hi;

    typedef enum logic [1:0] {IDLE, PHASE, CAP, LOAD} state_t;

    function automatic logic signed [pw-1:0] ext_p(input logic [data_width-1:0] x);
        return {{(pw-data_width){x[data_width-1]}}, x};
    endfunction

    function automatic logic signed [ow-1:0] ext_o(input logic [data_width-1:0] x);
        return {{(ow-data_width){x[data_width-1]}}, x};
    endfunction

    function automatic logic [data_width-1:0] sat(input logic signed [pw-1:0] x);
        if (x > sat_hi) return sat_hi[data_width-1:0];
        if (x < sat_lo) return sat_lo[data_width-1:0];
        return x[data_width-1:0];
    endfunction

    state_t                 state;
    state_t                 state_nxt;
    logic [cnt_w-1:0]       phase_cnt;
    logic [n_phases-1:0]    snap_pwm;
    logic [data_width-1:0]  snap_vdc;
    logic [data_width-1:0]  il_q [n_phases];
    logic [data_width-1:0]  ic_q;
    logic [data_width-1:0]  vc_q;
    logic [data_width-1:0]  iload_q;

    logic signed [ow-1:0]   vl;
    logic signed [ow-1:0]   mul_a;
    logic signed [ow-1:0]   mul_b;
    logic signed [pw-1:0]   prod;
    logic signed [pw-1:0]   prod_sh;
    logic signed [pw-1:0]   ic_diff;
    logic [sw-1:0]          phase_sum;
    logic [data_width-1:0]  il_cur;
    logic [data_width-1:0]  il_next;
    logic [data_width-1:0]  ic_new;
    logic [data_width-1:0]  vc_new;
    logic [data_width-1:0]  iload_new;

    assign il_cur = il_q[phase_cnt];
    assign vl     = ext_o(snap_vdc) - (snap_pwm[phase_cnt] ? '0 : ext_o(vc_q));

    // Only open-switch phases feed the capacitor node.
    always_comb begin
        phase_sum = '0;
        for (int k = 0; k < n_phases; k++) begin
            if (!snap_pwm[k])
                phase_sum = phase_sum + {{(sw-data_width){il_q[k][data_width-1]}}, il_q[k]};
        end
        ic_diff = {{(pw-sw){phase_sum[sw-1]}}, phase_sum} - ext_p(iload_q);
        ic_new  = sat(ic_diff);
    end

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            PHASE: begin
                mul_a = vl;
                mul_b = ext_o(kL);
            end
            CAP: begin
                mul_a = ext_o(ic_new);
                mul_b = ext_o(kC);
            end
            LOAD: begin
                mul_a = ext_o(vc_q);
                mul_b = ext_o(kR);
            end
            default: ;
        endcase
    end

    assign prod    = $signed({{ow{mul_a[ow-1]}}, mul_a}) * $signed({{ow{mul_b[ow-1]}}, mul_b});
    assign prod_sh = prod >>> data_decimal;

    always_comb begin
        il_next = sat(prod_sh + ext_p(il_cur));
`ifdef OHS_BOOST_DCM_EN
        if (!snap_pwm[phase_cnt] && il_next[data_width-1])
            il_next = '0;
`endif
    end

    assign vc_new    = sat(prod_sh + ext_p(vc_q));
    assign iload_new = sat(prod_sh);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ce) state_nxt = PHASE;
            PHASE:   if (phase_cnt == last_phase) state_nxt = CAP;
            CAP:     state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state     <= IDLE;
            phase_cnt <= '0;
            snap_pwm  <= '0;
            snap_vdc  <= '0;
            ic_q      <= '0;
            vc_q      <= '0;
            iload_q   <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            // NOTE: the phase-current array is real model state, so it is reset like any other register.
            for (int k = 0; k < n_phases; k++) il_q[k] <= '0;
        end else begin
            state <= state_nxt;
            valid <= 1'b0;
            if (ce && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (ce) begin
                        snap_pwm  <= S_pwm;
                        snap_vdc  <= vdc;
                        phase_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                PHASE: begin
                    il_q[phase_cnt] <= il_next;
                    phase_cnt       <= phase_cnt + 1'b1;
                end
                CAP: begin
                    ic_q <= ic_new;
                    vc_q <= vc_new;
                end
                LOAD: begin
                    iload_q <= iload_new;
                    busy    <= 1'b0;
                    valid   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        iL = '0;
        for (int k = 0; k < n_phases; k++) iL[k*data_width +: data_width] = il_q[k];
    end

    assign iC    = ic_q;
    assign vC    = vc_q;
    assign iLoad = iload_q;

endmodule
